// File: rtl/module_bcdabin_pkg.sv
// Shared types and constants for the keypad BCD-to-binary converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package module_bcdabin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no digits collected
        ACC  = 2'd1,   // 1..NDIG digits collected
        CONV = 2'd2,   // reverse double-dabble iterations
        DONE = 2'd3    // result published, entry state cleared
    } state_t;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ_THR = 4'd8;
    localparam logic [3:0] BCD_ADJ     = 4'd3;

endpackage

// File: rtl/module_bcdabin_if.sv
// Keypad-entry bus between the digit decoder (master) and the converter (slave).
// Latency: n/a (wires only).
// Backpressure: master must hold off digit_valid/enter while ready is low.
// Ports: digit_valid/digit/enter/clear from master; ready/bin_out/bin_valid/err from slave.
interface module_bcdabin_if #(
    parameter int WIDTH = 8
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             enter;
    logic             clear;
    logic             ready;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             err;

    modport master (
        output digit_valid, digit, enter, clear,
        input  ready, bin_out, bin_valid, err
    );

    modport slave (
        input  digit_valid, digit, enter, clear,
        output ready, bin_out, bin_valid, err
    );
endinterface

// File: rtl/module_bcd_digit_adj.sv
// One BCD nibble correction step of reverse double-dabble: subtract 3 when >= 8.
// Latency: combinational.
// Backpressure: none.
// Ports: din (4-bit nibble after shift), dout (corrected nibble).
module module_bcd_digit_adj
    import module_bcdabin_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THR) ? (din - BCD_ADJ) : din;

endmodule

// File: rtl/module_bcdabin.sv
// Collects BCD digits MSD-first and converts them to binary by reverse double-dabble.
// Latency: bin_valid 4*NDIG+1 cycles after the enter edge (9 cycles for NDIG=2).
// Backpressure: ready low during CONV/DONE; digits and enter are ignored then.
// Ports: clk, rst (sync, active-high), bus (module_bcdabin_if.slave).
// Build option: define BCDABIN_SAT_EN to saturate bin_out on overflow instead of wrapping.
module module_bcdabin
    import module_bcdabin_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    module_bcdabin_if.slave   bus
);

    localparam int BW    = 4 * NDIG;                       // BCD and shift register width
    localparam int CW    = $clog2(NDIG + 1);               // digit count width
    localparam int IW    = $clog2(4 * NDIG + 1);           // iteration count width
    localparam int RES_W = (BW > WIDTH) ? BW : WIDTH;      // room to detect overflow

    state_t           state_q, state_d;
    logic [BW-1:0]    bcd_q, sh_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    iter_q;
    logic [WIDTH-1:0] bin_out_q;
    logic             bin_valid_q, err_q;

    logic             digit_ok, cnt_full, conv_last;
    logic [2*BW-1:0]  pair_sh;
    logic [BW-1:0]    bcd_adj;
    logic [RES_W-1:0] res_ext;
    logic             ovf;
    logic [WIDTH-1:0] res_out;

    assign digit_ok  = (bus.digit <= BCD_MAX);
    assign cnt_full  = (cnt_q == CW'(NDIG));
    // After 4*NDIG iterations the binary value sits in the shift register.
    assign conv_last = (iter_q == IW'(4 * NDIG));

    // One iteration: shift the {BCD, shift} pair right, then correct each nibble.
    assign pair_sh = {bcd_q, sh_q} >> 1;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        module_bcd_digit_adj u_adj (
            .din  (pair_sh[BW + 4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    assign res_ext = RES_W'(sh_q);
    assign ovf     = ((res_ext >> WIDTH) != '0);

`ifdef BCDABIN_SAT_EN
    assign res_out = ovf ? '1 : res_ext[WIDTH-1:0];
`else
    assign res_out = res_ext[WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; clear outranks enter, which outranks a digit.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (bus.enter)
                        state_d = CONV;
                    else if (bus.digit_valid && digit_ok && !cnt_full)
                        state_d = ACC;
                end
                CONV:    if (conv_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        bus.ready = (state_q == IDLE) || (state_q == ACC);
    end

    // Datapath: entry register, conversion iterations and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            iter_q      <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bin_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (bus.clear) begin
                bcd_q  <= '0;
                sh_q   <= '0;
                cnt_q  <= '0;
                iter_q <= '0;
            end else begin
                case (state_q)
                    IDLE, ACC: begin
                        if (bus.enter) begin
                            sh_q   <= '0;
                            iter_q <= '0;
                        end else if (bus.digit_valid) begin
                            if (!digit_ok) begin
                                err_q <= 1'b1;
                            end else if (!cnt_full) begin
                                bcd_q <= (bcd_q << 4) | BW'(bus.digit);
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    CONV: begin
                        if (conv_last) begin
                            bin_out_q   <= res_out;
                            bin_valid_q <= 1'b1;
                            err_q       <= ovf;
                        end else begin
                            bcd_q  <= bcd_adj;
                            sh_q   <= pair_sh[BW-1:0];
                            iter_q <= iter_q + 1'b1;
                        end
                    end
                    DONE: begin
                        bcd_q  <= '0;
                        sh_q   <= '0;
                        cnt_q  <= '0;
                        iter_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bin_out   = bin_out_q;
    assign bus.bin_valid = bin_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_module_bcdabin.sv
// Directed bench for module_bcdabin: table of digit entries plus hand-written corner sequences.
// Latency: checks bin_valid exactly 9 cycles after enter (NDIG=2).
// Backpressure: checks ready drops during conversion and returns after the result.
module tb_module_bcdabin;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    module_bcdabin_if #(.WIDTH(8)) ifa ();
    module_bcdabin_if #(.WIDTH(6)) ifb ();

    // Narrow instance mirrors the stimulus of the wide one.
    assign ifb.digit_valid = ifa.digit_valid;
    assign ifb.digit       = ifa.digit;
    assign ifb.enter       = ifa.enter;
    assign ifb.clear       = ifa.clear;

    module_bcdabin #(.NDIG(2), .WIDTH(8)) dut_w (.clk(clk), .rst(rst), .bus(ifa));
    module_bcdabin #(.NDIG(2), .WIDTH(6)) dut_n (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        int       n;
        logic [3:0] d0, d1, d2;
        int       exp_val;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        ifa.digit_valid = 1'b1;
        ifa.digit       = d;
        tick();
        ifa.digit_valid = 1'b0;
        ifa.digit       = 4'd0;
    endtask

    // Pulses enter and checks the result against exp / exp_err on the wide instance.
    task automatic convert(input string nm, input int exp, input int exp_err);
        int early;
        early = 0;
        ifa.enter = 1'b1;
        tick();
        ifa.enter = 1'b0;
        chk({nm, " ready_low_conv"}, int'(ifa.ready), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ifa.bin_valid) early++;
        end
        chk({nm, " no_early_valid"}, early, 0);
        tick();
        chk({nm, " bin_valid"}, int'(ifa.bin_valid), 1);
        chk({nm, " bin_out"}, int'(ifa.bin_out), exp);
        chk({nm, " err"}, int'(ifa.err), exp_err);
        tick();
        chk({nm, " valid_one_cycle"}, int'(ifa.bin_valid), 0);
        chk({nm, " ready_back"}, int'(ifa.ready), 1);
    endtask

    initial begin
        int cnt_v;
        int exp_n;
        vecs[0] = '{2, 4'd8, 4'd1, 4'd0, 81};
        vecs[1] = '{1, 4'd4, 4'd0, 4'd0, 4};
        vecs[2] = '{0, 4'd0, 4'd0, 4'd0, 0};
        vecs[3] = '{2, 4'd3, 4'd7, 4'd0, 37};
        vecs[4] = '{3, 4'd1, 4'd2, 4'd3, 12};
        vecs[5] = '{2, 4'd9, 4'd9, 4'd0, 99};
        vecs[6] = '{2, 4'd0, 4'd9, 4'd0, 9};
        vecs[7] = '{3, 4'd2, 4'd5, 4'd5, 25};
        vecs[8] = '{2, 4'd5, 4'd5, 4'd0, 55};

        ifa.digit_valid = 1'b0;
        ifa.digit       = 4'd0;
        ifa.enter       = 1'b0;
        ifa.clear       = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("reset ready", int'(ifa.ready), 1);
        chk("reset bin_out", int'(ifa.bin_out), 0);
        chk("reset bin_valid", int'(ifa.bin_valid), 0);
        chk("reset err", int'(ifa.err), 0);

        // Table-driven entries; the third digit (when present) must be dropped silently.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].n > 0) send_digit(vecs[i].d0);
            if (vecs[i].n > 1) send_digit(vecs[i].d1);
            if (vecs[i].n > 2) begin
                send_digit(vecs[i].d2);
                chk($sformatf("vec%0d drop_no_err", i), int'(ifa.err), 0);
            end
            convert($sformatf("vec%0d", i), vecs[i].exp_val, 0);
        end

        // Invalid digit between two good ones: err next cycle, register untouched.
        send_digit(4'd3);
        send_digit(4'hA);
        chk("bad_digit err", int'(ifa.err), 1);
        chk("bad_digit ready", int'(ifa.ready), 1);
        tick();
        chk("bad_digit err_one_cycle", int'(ifa.err), 0);
        send_digit(4'd7);
        convert("after_bad", 37, 0);

        // Restore a known result of 55, then abort a conversion with clear.
        send_digit(4'd5);
        send_digit(4'd5);
        convert("pre_clear", 55, 0);
        send_digit(4'd2);
        send_digit(4'd0);
        ifa.enter = 1'b1;
        tick();
        ifa.enter = 1'b0;
        tick();
        tick();
        tick();
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        chk("clear ready", int'(ifa.ready), 1);
        cnt_v = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ifa.bin_valid) cnt_v++;
        end
        chk("clear no_valid", cnt_v, 0);
        chk("clear bin_out_held", int'(ifa.bin_out), 55);
        // Cleared entry must convert as zero.
        convert("after_clear", 0, 0);

        // Overflow on the 6-bit instance.
        send_digit(4'd9);
        send_digit(4'd9);
        ifa.enter = 1'b1;
        tick();
        ifa.enter = 1'b0;
        for (int k = 0; k < 9; k++) tick();
`ifdef BCDABIN_SAT_EN
        exp_n = 63;
`else
        exp_n = 35;
`endif
        chk("ovf bin_valid", int'(ifb.bin_valid), 1);
        chk("ovf err", int'(ifb.err), 1);
        chk("ovf bin_out", int'(ifb.bin_out), exp_n);
        chk("ovf wide bin_out", int'(ifa.bin_out), 99);
        chk("ovf wide err", int'(ifa.err), 0);
        tick();
        chk("ovf err_one_cycle", int'(ifb.err), 0);

        // Reset in the middle of a conversion.
        send_digit(4'd4);
        send_digit(4'd2);
        ifa.enter = 1'b1;
        tick();
        ifa.enter = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_conv bin_out", int'(ifa.bin_out), 0);
        chk("rst_conv ready", int'(ifa.ready), 1);
        cnt_v = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ifa.bin_valid || ifb.bin_valid) cnt_v++;
        end
        chk("rst_conv no_valid", cnt_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_bcdabin.md
# module_bcdabin

Sequential BCD-to-binary converter for keypad operand entry. Collects decimal digits most-significant first from the keypad decoder and packs them into a BCD register. On `enter` it converts the register to binary with a reverse double-dabble: shift right, then subtract 3 from each digit that is ≥8. The result feeds the arithmetic datapath as an unsigned operand, the inverse of the display-side binary-to-BCD path.

## Interface
Parameters:
- `NDIG`, 2, maximum decimal digits accepted per operand (≥1)
- `WIDTH`, 8, binary result width

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous and active-high
- `digit_valid`  in  1  one-cycle strobe, `digit` is valid
- `digit`  in  4  BCD digit 0..9
- `enter`  in  1  one-cycle strobe, convert digits collected so far
- `clear`  in  1  one-cycle strobe, discard entry or abort conversion
- `ready`  out  1  high when digits/enter are accepted
- `bin_out`  out  WIDTH  last converted value, held until next result
- `bin_valid`  out  1  one-cycle pulse, `bin_out` updated this cycle
- `err`  out  1  one-cycle pulse: invalid digit or result overflow

## Operation
- States: `IDLE` (0 digits), `ACC` (1..NDIG digits), `CONV`, `DONE`.
- Reset: state `IDLE`, BCD register 0, digit count 0, `bin_out`=0, `bin_valid`=0, `err`=0, `ready`=1.
- Priority in every state: `rst` > `clear` > `enter` > `digit_valid`.
- Digit entry in `IDLE` or `ACC` with `digit_valid` and `digit`≤9:
  - BCD register shifts left 4 and `digit` fills the low nibble; count increments; state becomes `ACC`.
  - When count==NDIG, further digits are silently dropped; no `err`.
- `digit`>9 with `digit_valid`: digit rejected, `err` pulses next cycle, state and register unchanged.
- `enter` in `IDLE` or `ACC`: go to `CONV`. Any digit on the same cycle is discarded. `enter` in `IDLE` converts 0.
- `CONV` runs exactly 4·NDIG iterations on the {BCD, shift} pair, where the shift register is 4·NDIG bits. Each iteration:
  - shift the whole pair right 1;
  - adjust each BCD nibble ≥8 by −3.
- Result after `CONV` = Σ digit_i·10^i.
- `DONE`: load `bin_out`, pulse `bin_valid`, clear the BCD register and count, return to `IDLE`.
- Overflow when result > 2^WIDTH−1; `err` pulses together with `bin_valid`.
- `ready`=1 in `IDLE`/`ACC`, 0 in `CONV`/`DONE`. `digit_valid`/`enter` ignored while `ready`=0.
- `clear` in any state: next state `IDLE`, register and count 0, no `bin_valid`, `bin_out` retains its previous value.

## Timing
- `enter` sampled at edge t: `CONV` occupies t+1..t+4·NDIG, `DONE` at t+4·NDIG+1.
  - `bin_valid`/`bin_out` visible after edge t+4·NDIG+1: 9 cycles for NDIG=2.
- `ready` returns to 1 the cycle after `bin_valid`.
- Digit acceptance is single-cycle; back-to-back `digit_valid` every cycle is supported.
- `err` for an invalid digit is registered: one cycle after the strobe.
- `rst` mid-`CONV` acts as reset: `bin_out`=0 and no pulse follows.

## Configuration
- `BCDABIN_SAT_EN` defined: on overflow `bin_out` = all ones (2^WIDTH−1).
- `BCDABIN_SAT_EN` undefined: on overflow `bin_out` = result mod 2^WIDTH.
- `err` pulses on overflow in both builds.

## Structure
- Package `module_bcdabin_pkg` holds:
  - the state enum type;
  - constants `BCD_MAX`=9, `BCD_ADJ_THR`=8, `BCD_ADJ`=3.
- Sub-module `module_bcd_digit_adj` is combinational: 4-bit in, 4-bit out, subtracts 3 when input ≥8. It is instantiated NDIG times in a generate loop.
- Top module holds the FSM, digit counter, BCD/shift registers and iteration counter (width clog2(4·NDIG+1)).

## Test plan
- NDIG=2, WIDTH=8: digits 8,1, then `enter` → 9 cycles later `bin_out`=81 (0x51), `bin_valid` high exactly 1 cycle, `err`=0.
- Digit 4, then `enter` → `bin_out`=4. Then `enter` with no digits → `bin_out`=0, `bin_valid` pulses.
- Digit 0xA → `err` pulse next cycle, no state change. Then 3,7, `enter` → `bin_out`=37.
- Digits 1,2,3, then `enter` → third digit dropped, `bin_out`=12, no `err`.
- After a result of 55, digits 2,0, `enter`, then `clear` 3 cycles into `CONV` → no `bin_valid`, `ready`=1 next cycle, `bin_out` stays 55.
- WIDTH=6: digits 9,9, `enter` → `err`+`bin_valid`. `bin_out`=63 with `BCDABIN_SAT_EN`, 35 (99 mod 64) without.
